// File: rtl/forward_mem_hist.sv
// forward_mem_hist: store-data forwarding for a store in the MEM stage.
// The current writeback and a DEPTH-entry history of recent writebacks are
// searched for the store's Rt register. The youngest match supplies the
// store data, and its age is reported.
// Optional build macro FORWARD_MEM_HIST_STATS_EN adds a saturating 16-bit
// fwdCount output that counts unstalled forwarding cycles.
module forward_mem_hist #(
    parameter int          REG_W  = 3,
    parameter int          DATA_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              wbEn,
    input  logic [REG_W-1:0]  wbReg,
    input  logic [DATA_W-1:0] wbData,
    input  logic              MemWriteExMem,
    input  logic              RtValidExMem,
    input  logic [REG_W-1:0]  RtExMem,
    input  logic [DATA_W-1:0] rtDataExMem,
    output logic [DATA_W-1:0] storeData,
    output logic              forwardC,
    output logic [2:0]        fwdAge
`ifdef FORWARD_MEM_HIST_STATS_EN
    ,
    output logic [15:0]       fwdCount
`endif
);

    logic              hist_valid [DEPTH];
    logic [REG_W-1:0]  hist_reg   [DEPTH];
    logic [DATA_W-1:0] hist_data  [DEPTH];

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [2:0]        hit_age;

    // History shift register: flush clears valids, stall holds, otherwise shift in writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_valid[i] <= 1'b0;
                hist_reg[i]   <= '0;
                hist_data[i]  <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_valid[i] <= 1'b0;
            end
        end else if (!stall) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_reg[i]   <= hist_reg[i-1];
                hist_data[i]  <= hist_data[i-1];
            end
            hist_valid[0] <= wbEn;
            hist_reg[0]   <= wbReg;
            hist_data[0]  <= wbData;
        end
    end

    // Priority match: scan oldest to youngest so the youngest match overrides.
    // The current writeback is checked last and therefore wins.
    // With DEPTH=8 the oldest entry's age (8) does not fit the 3-bit port and wraps to 0.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_age  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (hist_valid[DEPTH-1-k] && (hist_reg[DEPTH-1-k] == RtExMem)) begin
                hit      = 1'b1;
                hit_data = hist_data[DEPTH-1-k];
                hit_age  = 3'(DEPTH - k);
            end
        end
        if (wbEn && (wbReg == RtExMem)) begin
            hit      = 1'b1;
            hit_data = wbData;
            hit_age  = '0;
        end
    end

    // Output select: forward only for a real store with a valid Rt field
    always_comb begin
        forwardC  = 1'b0;
        storeData = rtDataExMem;
        fwdAge    = '0;
        if (MemWriteExMem && RtValidExMem && hit) begin
            forwardC  = 1'b1;
            storeData = hit_data;
            fwdAge    = hit_age;
        end
    end

`ifdef FORWARD_MEM_HIST_STATS_EN
    // Saturating count of unstalled forwarding cycles; flush does not affect it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdCount <= '0;
        end else if (forwardC && !stall && (fwdCount != 16'hFFFF)) begin
            fwdCount <= fwdCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_mem_hist.sv
// Testbench for forward_mem_hist (default parameters, DEPTH=2).
// A cycle-by-cycle vector table is followed by a hand-written sequence that
// applies reset in the middle of a stall. The fwdCount checks are active
// when FORWARD_MEM_HIST_STATS_EN is defined.
module tb_forward_mem_hist;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        wb_en;
        logic [2:0]  wb_reg;
        logic [15:0] wb_data;
        logic        st;
        logic        rtv;
        logic [2:0]  rt;
        logic [15:0] rtd;
        logic        efwd;
        logic [15:0] edata;
        logic [2:0]  eage;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wbEn = 1'b0;
    logic [2:0]  wbReg = '0;
    logic [15:0] wbData = '0;
    logic        MemWriteExMem = 1'b0;
    logic        RtValidExMem = 1'b0;
    logic [2:0]  RtExMem = '0;
    logic [15:0] rtDataExMem = '0;
    logic [15:0] storeData;
    logic        forwardC;
    logic [2:0]  fwdAge;
`ifdef FORWARD_MEM_HIST_STATS_EN
    logic [15:0] fwdCount;
`endif

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned model_cnt = 0;
    vec_t        tbl[$];
    vec_t        exp_q[$];

    forward_mem_hist #(.REG_W(3), .DATA_W(16), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .wbEn(wbEn),
        .wbReg(wbReg),
        .wbData(wbData),
        .MemWriteExMem(MemWriteExMem),
        .RtValidExMem(RtValidExMem),
        .RtExMem(RtExMem),
        .rtDataExMem(rtDataExMem),
        .storeData(storeData),
        .forwardC(forwardC),
        .fwdAge(fwdAge)
`ifdef FORWARD_MEM_HIST_STATS_EN
        ,
        .fwdCount(fwdCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic f, input logic we,
                                input logic [2:0] wr, input logic [15:0] wd,
                                input logic st, input logic rv, input logic [2:0] rt,
                                input logic [15:0] rd, input logic ef,
                                input logic [15:0] ed, input logic [2:0] ea);
        vec_t v;
        v.stall = s; v.flush = f; v.wb_en = we; v.wb_reg = wr; v.wb_data = wd;
        v.st = st; v.rtv = rv; v.rt = rt; v.rtd = rd;
        v.efwd = ef; v.edata = ed; v.eage = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; flush = v.flush;
        wbEn = v.wb_en; wbReg = v.wb_reg; wbData = v.wb_data;
        MemWriteExMem = v.st; RtValidExMem = v.rtv; RtExMem = v.rt; rtDataExMem = v.rtd;
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " forwardC"}, 32'(forwardC), 32'(e.efwd));
        check({tag, " storeData"}, 32'(storeData), 32'(e.edata));
        check({tag, " fwdAge"}, 32'(fwdAge), 32'(e.eage));
`ifdef FORWARD_MEM_HIST_STATS_EN
        check({tag, " fwdCount"}, 32'(fwdCount), model_cnt);
`endif
    endtask

    // Entered one time unit after a rising edge; returns at the same phase.
    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #4;
        compare(tag);
        @(posedge clk);
        if (rst) model_cnt = 0;
        else if (v.efwd && !v.stall && model_cnt != 32'hFFFF) model_cnt++;
        #1;
    endtask

    initial begin
        // Rows are applied one per cycle; history carries from row to row.
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,3,16'h1111, 0,16'h1111,0)); // 0 empty history
        tbl.push_back(mk(0,0,1,3,16'hAAAA, 1,1,3,16'h1111, 1,16'hAAAA,0)); // 1 same-cycle wb
        tbl.push_back(mk(0,0,1,3,16'h0001, 0,1,3,16'h2222, 0,16'h2222,0)); // 2 no store
        tbl.push_back(mk(0,0,1,3,16'h0002, 0,1,3,16'h2222, 0,16'h2222,0)); // 3
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,3,16'h1111, 1,16'h0002,1)); // 4 newest wins
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,3,16'h1111, 1,16'h0002,2)); // 5 oldest entry
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,3,16'h1111, 0,16'h1111,0)); // 6 aged out
        tbl.push_back(mk(0,0,1,3,16'h1234, 1,0,3,16'h1111, 0,16'h1111,0)); // 7 Rt invalid
        tbl.push_back(mk(0,0,1,5,16'h5555, 1,1,5,16'h0000, 1,16'h5555,0)); // 8
        tbl.push_back(mk(1,0,1,6,16'h6666, 1,1,5,16'h0000, 1,16'h5555,1)); // 9 stall
        tbl.push_back(mk(1,0,0,0,16'h0000, 1,1,3,16'h0000, 1,16'h1234,2)); // 10 stall
        tbl.push_back(mk(1,0,0,0,16'h0000, 1,1,6,16'h7777, 0,16'h7777,0)); // 11 stalled wb dropped
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,5,16'h0000, 1,16'h5555,1)); // 12
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,5,16'h0000, 1,16'h5555,2)); // 13
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,5,16'h4444, 0,16'h4444,0)); // 14 aged out
        tbl.push_back(mk(0,0,1,2,16'hBEEF, 1,1,0,16'h0000, 0,16'h0000,0)); // 15
        tbl.push_back(mk(0,1,1,0,16'h0F0F, 1,1,2,16'h0101, 1,16'hBEEF,1)); // 16 flush sees pre-flush
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,2,16'h0101, 0,16'h0101,0)); // 17 flushed
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,0,16'h0001, 0,16'h0001,0)); // 18 flush dropped wb
        tbl.push_back(mk(0,0,1,0,16'h00AA, 1,1,0,16'h0000, 1,16'h00AA,0)); // 19 reg 0 ordinary
        tbl.push_back(mk(0,0,1,0,16'h00BB, 1,1,0,16'h0000, 1,16'h00BB,0)); // 20 age0 over entry0
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,0,16'h0000, 1,16'h00BB,1)); // 21 entry0 over entry1
        tbl.push_back(mk(1,1,0,0,16'h0000, 1,1,0,16'h0000, 1,16'h00BB,2)); // 22 flush during stall
        tbl.push_back(mk(0,0,0,0,16'h0000, 1,1,0,16'h0003, 0,16'h0003,0)); // 23 flushed

        // Reset held: history inputs ignored, age-0 path still forwards.
        #1;
        apply(mk(0,0,1,4,16'h4444, 1,1,4,16'h0001, 1,16'h4444,0), "rst_a");
        apply(mk(0,0,1,4,16'h4444, 1,1,3,16'h1111, 0,16'h1111,0), "rst_b");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Reset in the middle of a stall empties history.
        apply(mk(0,0,1,4,16'h4444, 0,1,4,16'h0000, 0,16'h0000,0), "ms_load");
        drive(mk(1,0,0,0,16'h0000, 1,1,4,16'h0009, 1,16'h4444,1));
        #2;
        compare("ms_stalled");
        rst = 1'b1;
        model_cnt = 0;
        drive(mk(1,0,0,0,16'h0000, 1,1,4,16'h0009, 0,16'h0009,0));
        #1;
        compare("ms_in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(0,0,0,0,16'h0000, 1,1,4,16'h0009, 0,16'h0009,0), "ms_after");
        apply(mk(0,0,1,1,16'h1010, 1,1,1,16'h0000, 1,16'h1010,0), "ms_fwd");
        apply(mk(0,0,0,0,16'h0000, 1,1,1,16'h0000, 1,16'h1010,1), "ms_hist");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/forward_mem_hist.md
FORWARD_MEM_HIST -- requirements
Module: forward_mem_hist

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-index width.
REQ-002 SHALL have parameter DATA_W, default 16, datapath width.
REQ-003 SHALL have parameter DEPTH, default 2, writeback-history entries (1..8).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  pipeline stall; freezes history.
REQ-007 SHALL have port flush  input  1  invalidates all history entries.
REQ-008 SHALL have port wbEn  input  1  register write retiring this cycle.
REQ-009 SHALL have port wbReg  input  REG_W  writeback destination index.
REQ-010 SHALL have port wbData  input  DATA_W  writeback value.
REQ-011 SHALL have port MemWriteExMem  input  1  store in MEM stage.
REQ-012 SHALL have port RtValidExMem  input  1  store Rt field valid.
REQ-013 SHALL have port RtExMem  input  REG_W  store data register index.
REQ-014 SHALL have port rtDataExMem  input  DATA_W  store data from pipeline latch.
REQ-015 SHALL have port storeData  output  DATA_W  corrected store data.
REQ-016 SHALL have port forwardC  output  1  forwarding taken this cycle.
REQ-017 SHALL have port fwdAge  output  3  age of selected entry (0 = current wbEn).

Function
REQ-018 SHALL hold DEPTH history entries {valid, reg, data}; entry 0 newest.
REQ-019 On clk rise with stall=0, flush=0: entries shift one older, entry 0 loads {wbEn, wbReg, wbData}; oldest entry discarded.
REQ-020 On clk rise with stall=1, flush=0: history SHALL hold unchanged.
REQ-021 On clk rise with flush=1: all valid bits SHALL clear, regardless of stall or wbEn.
REQ-022 Match candidate = current wbEn/wbReg (age 0), then history entries (age 1..DEPTH).
REQ-023 forwardC SHALL be combinational: MemWriteExMem & RtValidExMem & any valid candidate with reg == RtExMem.
REQ-024 On multiple matches, youngest candidate SHALL win (current writeback over entry 0 over entry 1 ...).
REQ-025 storeData SHALL equal winning candidate data when forwardC=1, else rtDataExMem.
REQ-026 fwdAge SHALL give winner age when forwardC=1, else 0.
REQ-027 Lookup SHALL see pre-edge history; same-cycle wbEn visible only via age-0 path.
REQ-028 Register index 0 SHALL be treated as an ordinary register (no hardwired zero).
REQ-029 Same-cycle flush and match: forwardC still reflects pre-flush history that cycle.

Reset
REQ-030 rst=1 SHALL asynchronously clear all valid bits, reg and data fields to 0.
REQ-031 During reset, forwardC SHALL be 0 unless current wbEn matches; storeData follows REQ-025.
REQ-032 Reset mid-stall SHALL empty history; first post-reset edge behaves per REQ-019/020.
REQ-033 Statistics counter (if present) SHALL reset to 0.

Configuration
REQ-034 Macro FORWARD_MEM_HIST_STATS_EN SHALL add output fwdCount (16 bits).
REQ-035 With macro: fwdCount increments on each clk rise where forwardC=1 and stall=0; saturates at 16'hFFFF; unaffected by flush.
REQ-036 Without macro: no fwdCount port, no counter logic; all other behaviour identical.

Verification
REQ-037 Reset, then store Rt=3, rtDataExMem=16'h1111, no writes -> forwardC=0, storeData=16'h1111.
REQ-038 wbEn reg3=16'hAAAA same cycle as store Rt=3 -> forwardC=1, fwdAge=0, storeData=16'hAAAA.
REQ-039 Write reg3=16'h0001, next cycle write reg3=16'h0002, then store Rt=3 -> storeData=16'h0002, fwdAge=1.
REQ-040 Write reg5=16'h5555, stall=1 for 3 cycles, then store Rt=5 -> forwardC=1, fwdAge=1; with DEPTH=2 and 2 unstalled idle cycles -> forwardC=0.
REQ-041 Write reg2=16'hBEEF, flush=1 one cycle, store Rt=2 -> forwardC=0, storeData=rtDataExMem.
REQ-042 STATS_EN: 70000 consecutive forwarding cycles -> fwdCount=16'hFFFF; assert rst mid-sequence -> fwdCount=0 immediately.
